// File: rtl/bp_pkg.sv
// Shared helpers for the branch predictor: saturating counter update and
// weak-taken / weak-not-taken encodings for a counter of a given width.
package bp_pkg;

    // Widest direction counter supported by the helpers below
    localparam int unsigned CTR_BITS_MAX = 4;

    // Weakly-taken encoding: MSB set, all lower bits clear
    function automatic logic [CTR_BITS_MAX-1:0] weak_taken(input int unsigned width);
        return CTR_BITS_MAX'(1 << (width - 1));
    endfunction

    // Weakly-not-taken encoding: MSB clear, all lower bits set
    function automatic logic [CTR_BITS_MAX-1:0] weak_not_taken(input int unsigned width);
        return CTR_BITS_MAX'((1 << (width - 1)) - 1);
    endfunction

    // Step a counter toward the observed outcome, clamping at 0 and 2^width-1
    function automatic logic [CTR_BITS_MAX-1:0] sat_update(
        input logic [CTR_BITS_MAX-1:0] state,
        input logic                    taken,
        input int unsigned             width
    );
        logic [CTR_BITS_MAX-1:0] max_val;
        max_val = CTR_BITS_MAX'((1 << width) - 1);
        if (taken) begin
            return (state >= max_val) ? max_val : state + 1'b1;
        end
        return (state == '0) ? '0 : state - 1'b1;
    endfunction

endpackage

// File: rtl/branch_pred_btb.sv
// Branch target buffer with saturating-counter direction predictor.
// Lookup is combinational on fetch_pc; ID-stage resolution updates one entry
// per cycle. Optional gshare indexing is enabled by defining BP_GSHARE_EN.
module branch_pred_btb
    import bp_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ENTRIES   = 16,
    parameter int unsigned CTR_BITS  = 2,
    parameter int unsigned HIST_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [XLEN-1:0]      fetch_pc,
    output logic                 pred_hit,
    output logic                 pred_taken,
    output logic [XLEN-1:0]      pred_target,
    output logic [CTR_BITS-1:0]  pred_state,
    output logic [HIST_BITS-1:0] pred_hist,
    input  logic                 upd_en,
    input  logic [XLEN-1:0]      upd_pc,
    input  logic                 upd_taken,
    input  logic [XLEN-1:0]      upd_target,
    input  logic [CTR_BITS-1:0]  upd_state,
    input  logic [HIST_BITS-1:0] upd_hist,
    input  logic                 upd_mispredict
);

    localparam int unsigned IDX_BITS = $clog2(ENTRIES);
    localparam int unsigned TAG_BITS = XLEN - IDX_BITS - 2;

    localparam logic [CTR_BITS-1:0] CTR_WEAK_T  = CTR_BITS'(weak_taken(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = CTR_BITS'(weak_not_taken(CTR_BITS));

    typedef struct packed {
        logic                valid;
        logic [TAG_BITS-1:0] tag;
        logic [XLEN-1:0]     target;
    } btb_entry_t;

    btb_entry_t          entries_q [ENTRIES];
    btb_entry_t          entries_d [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q     [ENTRIES];
    logic [CTR_BITS-1:0] ctr_d     [ENTRIES];

    logic [IDX_BITS-1:0] lkp_idx;
    logic [TAG_BITS-1:0] lkp_tag;
    logic [IDX_BITS-1:0] upd_idx;
    logic [TAG_BITS-1:0] upd_tag;
    btb_entry_t          lkp_entry;
    btb_entry_t          upd_entry;
    logic                upd_hit;

    assign lkp_tag = fetch_pc[XLEN-1:IDX_BITS+2];
    assign upd_tag = upd_pc[XLEN-1:IDX_BITS+2];

`ifdef BP_GSHARE_EN
    logic [HIST_BITS-1:0] ghr_q;
    logic [HIST_BITS-1:0] ghr_d;
    logic [HIST_BITS-1:0] ghr_base;
    logic [1:0]           unused_upd_pc;

    assign unused_upd_pc = upd_pc[1:0];

    // Prediction hashes with the live GHR; update rehashes with the snapshot taken at fetch
    assign lkp_idx   = fetch_pc[IDX_BITS+1:2] ^ IDX_BITS'(ghr_q);
    assign upd_idx   = upd_pc[IDX_BITS+1:2] ^ IDX_BITS'(upd_hist);
    assign pred_hist = ghr_q;

    // Next GHR: shift in the outcome, rebuilding from the fetch snapshot on a mispredict
    always_comb begin
        ghr_d    = ghr_q;
        ghr_base = upd_mispredict ? upd_hist : ghr_q;
        if (upd_en) begin
            // Truncating cast drops the oldest bit, which also covers HIST_BITS == 1
            ghr_d = HIST_BITS'({ghr_base, upd_taken});
        end
    end

    // GHR register; reset clears history
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end
`else
    logic [HIST_BITS+2:0] unused_upd;

    assign unused_upd = {upd_hist, upd_mispredict, upd_pc[1:0]};

    assign lkp_idx   = fetch_pc[IDX_BITS+1:2];
    assign upd_idx   = upd_pc[IDX_BITS+1:2];
    assign pred_hist = '0;
`endif

    assign lkp_entry = entries_q[lkp_idx];
    assign upd_entry = entries_q[upd_idx];
    assign upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);

    // Same-cycle prediction from registered state (no bypass of a concurrent update)
    always_comb begin
        pred_hit    = lkp_entry.valid && (lkp_entry.tag == lkp_tag);
        pred_state  = pred_hit ? ctr_q[lkp_idx] : CTR_WEAK_NT;
        pred_taken  = pred_hit && pred_state[CTR_BITS-1];
        pred_target = pred_taken ? lkp_entry.target : fetch_pc + XLEN'(4);
    end

    // Next entry state from a resolved branch: train on hit, allocate on taken miss
    always_comb begin
        entries_d = entries_q;
        ctr_d     = ctr_q;
        if (upd_en) begin
            if (upd_hit) begin
                ctr_d[upd_idx] = CTR_BITS'(sat_update(CTR_BITS_MAX'(upd_state), upd_taken, CTR_BITS));
                if (upd_taken) begin
                    entries_d[upd_idx].target = upd_target;
                end
            end else if (upd_taken) begin
                entries_d[upd_idx].valid  = 1'b1;
                entries_d[upd_idx].tag    = upd_tag;
                entries_d[upd_idx].target = upd_target;
                ctr_d[upd_idx]            = CTR_WEAK_T;
            end
        end
    end

    // BTB storage; reset only invalidates, leaving tags, targets and counters stale
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                entries_q[i].valid <= 1'b0;
            end
        end else begin
            entries_q <= entries_d;
            ctr_q     <= ctr_d;
        end
    end

endmodule

// File: tb/tb_branch_pred_btb.sv
// Self-checking bench for branch_pred_btb: behavioural model compared every
// cycle, plus literal expectations for the directed scenarios.
module tb_branch_pred_btb;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned ENTRIES   = 16;
    localparam int unsigned CTR_BITS  = 2;
    localparam int unsigned HIST_BITS = 4;
    localparam int unsigned IDX_BITS  = 4;
    localparam int unsigned CTR_MAX   = (1 << CTR_BITS) - 1;
    localparam int unsigned WEAK_T    = 1 << (CTR_BITS - 1);
`ifdef BP_GSHARE_EN
    localparam bit GSHARE = 1'b1;
`else
    localparam bit GSHARE = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [XLEN-1:0]      fetch_pc = '0;
    logic                 pred_hit;
    logic                 pred_taken;
    logic [XLEN-1:0]      pred_target;
    logic [CTR_BITS-1:0]  pred_state;
    logic [HIST_BITS-1:0] pred_hist;
    logic                 upd_en = 1'b0;
    logic [XLEN-1:0]      upd_pc = '0;
    logic                 upd_taken = 1'b0;
    logic [XLEN-1:0]      upd_target = '0;
    logic [CTR_BITS-1:0]  upd_state = '0;
    logic [HIST_BITS-1:0] upd_hist = '0;
    logic                 upd_mispredict = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    branch_pred_btb #(
        .XLEN(XLEN), .ENTRIES(ENTRIES), .CTR_BITS(CTR_BITS), .HIST_BITS(HIST_BITS)
    ) dut (
        .clk(clk), .rst(rst), .fetch_pc(fetch_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .pred_state(pred_state), .pred_hist(pred_hist),
        .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_state(upd_state), .upd_hist(upd_hist), .upd_mispredict(upd_mispredict)
    );

    // ---------------- behavioural model ----------------
    bit              m_valid [ENTRIES];
    int unsigned     m_tag   [ENTRIES];
    logic [31:0]     m_tgt   [ENTRIES];
    int unsigned     m_ctr   [ENTRIES];
    int unsigned     m_ghr = 0;
    bit              model_ready = 1'b0;

    function automatic int unsigned m_index(input logic [31:0] pc, input int unsigned hist);
        return ((pc >> 2) ^ (GSHARE ? hist : 0)) % ENTRIES;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state advance on each rising edge
    initial forever begin
        int unsigned i;
        int unsigned t;
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
            m_ghr       = 0;
            model_ready = 1'b1;
        end else if (upd_en) begin
            i = m_index(upd_pc, upd_hist);
            t = upd_pc >> (IDX_BITS + 2);
            if (m_valid[i] && m_tag[i] == t) begin
                if (upd_taken) begin
                    m_ctr[i] = (upd_state + 1 > CTR_MAX) ? CTR_MAX : upd_state + 1;
                    m_tgt[i] = upd_target;
                end else begin
                    m_ctr[i] = (upd_state == 0) ? 0 : upd_state - 1;
                end
            end else if (upd_taken) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = t;
                m_tgt[i]   = upd_target;
                m_ctr[i]   = WEAK_T;
            end
            if (GSHARE)
                m_ghr = ((upd_mispredict ? upd_hist : m_ghr) * 2 + upd_taken) % (1 << HIST_BITS);
        end
    end

    // Per-cycle comparison against the model, mid-cycle
    initial forever begin
        int unsigned i;
        bit          e_hit;
        bit          e_tk;
        logic [31:0] e_tgt;
        int unsigned e_st;
        @(negedge clk);
        if (model_ready) begin
            i     = m_index(fetch_pc, m_ghr);
            e_hit = m_valid[i] && (m_tag[i] == (fetch_pc >> (IDX_BITS + 2)));
            e_st  = e_hit ? m_ctr[i] : WEAK_T - 1;
            e_tk  = e_hit && (e_st >= WEAK_T);
            e_tgt = e_tk ? m_tgt[i] : fetch_pc + 32'd4;
            check("cmp_hit",    64'(pred_hit),    64'(e_hit));
            check("cmp_taken",  64'(pred_taken),  64'(e_tk));
            check("cmp_target", 64'(pred_target), 64'(e_tgt));
            check("cmp_state",  64'(pred_state),  64'(e_st));
            check("cmp_hist",   64'(pred_hist),   64'(GSHARE ? m_ghr : 0));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        upd_en         = 1'b0;
        upd_mispredict = 1'b0;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic [1:0] st, input logic [3:0] hist, input logic misp);
        upd_en         = 1'b1;
        upd_pc         = pc;
        upd_taken      = tk;
        upd_target     = tgt;
        upd_state      = st;
        upd_hist       = hist;
        upd_mispredict = misp;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic pred_expect(input string name, input logic hit, input logic tk,
                               input logic [31:0] tgt, input logic [1:0] st);
        #1;
        check({name, "_hit"},    64'(pred_hit),    64'(hit));
        check({name, "_taken"},  64'(pred_taken),  64'(tk));
        check({name, "_target"}, 64'(pred_target), 64'(tgt));
        check({name, "_state"},  64'(pred_state),  64'(st));
    endtask

    initial begin
        int unsigned exp_st [7];
        logic [31:0] pcs [6];
        logic [1:0]  prev;
        exp_st = '{2, 3, 3, 3, 2, 1, 0};
        pcs    = '{32'h40, 32'h80, 32'hC0, 32'h44, 32'h100, 32'h4C};

        tick();
        tick();
        rst      = 1'b0;
        fetch_pc = 32'h40;
        pred_expect("reset_miss", 1'b0, 1'b0, 32'h44, 2'b01);
        fetch_pc = 32'hFFFF_FFFC;
        pred_expect("wrap", 1'b0, 1'b0, 32'h0, 2'b01);

`ifndef BP_GSHARE_EN
        // Allocation; lookup in the update cycle still sees the old entry
        fetch_pc = 32'h40;
        upd(32'h40, 1'b1, 32'h80, 2'b01, 4'h0, 1'b0);
        pred_expect("same_cycle", 1'b0, 1'b0, 32'h44, 2'b01);
        tick();
        idle();
        pred_expect("alloc", 1'b1, 1'b1, 32'h80, 2'b10);

        // Counter saturation in both directions
        do_reset();
        prev = 2'b01;
        for (int k = 0; k < 7; k++) begin
            upd(32'h40, (k < 4), 32'h80, prev, 4'h0, 1'b0);
            tick();
            idle();
            #1;
            check("sat_state", 64'(pred_state), 64'(exp_st[k]));
            check("sat_taken", 64'(pred_taken), 64'(exp_st[k] >= 2));
            prev = 2'(exp_st[k]);
        end

        // Conflict eviction at index 0
        do_reset();
        upd(32'h40, 1'b1, 32'h100, 2'b01, 4'h0, 1'b0);
        tick();
        upd(32'h80, 1'b1, 32'h200, 2'b01, 4'h0, 1'b0);
        tick();
        idle();
        fetch_pc = 32'h40;
        pred_expect("evicted", 1'b0, 1'b0, 32'h44, 2'b01);
        fetch_pc = 32'h80;
        pred_expect("evictor", 1'b1, 1'b1, 32'h200, 2'b10);

        // Not-taken miss leaves no trace; mispredict without upd_en ignored
        upd(32'hC0, 1'b0, 32'h300, 2'b01, 4'h0, 1'b0);
        tick();
        idle();
        upd_mispredict = 1'b1;
        fetch_pc = 32'hC0;
        pred_expect("nt_miss", 1'b0, 1'b0, 32'hC4, 2'b01);
        tick();
        idle();

        // Reset wins over a concurrent allocation
        fetch_pc = 32'h140;
        upd(32'h140, 1'b1, 32'h500, 2'b01, 4'h0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        pred_expect("rst_over_upd", 1'b0, 1'b0, 32'h144, 2'b01);
        fetch_pc = 32'h80;
        pred_expect("rst_clears", 1'b0, 1'b0, 32'h84, 2'b01);
`else
        // History shift and mispredict repair
        do_reset();
        upd(32'h40, 1'b1, 32'h80, 2'b01, 4'h0, 1'b0);
        tick();
        upd(32'h44, 1'b1, 32'h90, 2'b01, 4'h1, 1'b0);
        tick();
        upd(32'h48, 1'b0, 32'hA0, 2'b01, 4'h3, 1'b0);
        tick();
        idle();
        #1;
        check("ghr_shift", 64'(pred_hist), 64'(4'b0110));
        upd(32'h40, 1'b1, 32'h80, 2'b01, 4'b0001, 1'b1);
        tick();
        idle();
        #1;
        check("ghr_repair", 64'(pred_hist), 64'(4'b0011));
`endif

        // Mixed traffic checked by the model each cycle
        do_reset();
        for (int k = 0; k < 200; k++) begin
            fetch_pc = pcs[$urandom_range(0, 5)];
            if ($urandom_range(0, 2) != 0) begin
                upd(pcs[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
                    32'($urandom_range(0, 255)) << 2, 2'($urandom_range(0, 3)),
                    4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            end else begin
                idle();
                upd_mispredict = 1'($urandom_range(0, 1));
            end
            if (k == 120) rst = 1'b1;
            tick();
            rst = 1'b0;
        end
        idle();
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
